// File: rtl/ext_unit_pipe.sv
// Two-stage immediate extender: S1 clamps/masks/extends the raw field, S2 applies the mode shift and overflow flag.
// Latency 2, throughput 1, valid/ready at both ends; define EXT_STATS_EN to add the xfer_cnt transfer counter.
module ext_unit_pipe #(
    parameter int IN_W  = 26,
    parameter int OUT_W = 64,
    parameter int LEN_W = $clog2(IN_W + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [LEN_W-1:0] in_len,
    input  logic [1:0]       in_mode,
    input  logic [1:0]       in_hw,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_err
`ifdef EXT_STATS_EN
    ,
    output logic [31:0]      xfer_cnt
`endif
);

    localparam logic [LEN_W-1:0] IN_W_L = LEN_W'(IN_W);

    logic             s1_v_q;
    logic [OUT_W-1:0] s1_val_q, s1_val_d;
    logic [5:0]       s1_sh_q, s1_sh_d;
    logic             s1_err_q, s1_err_d;

    logic             s2_v_q;
    logic [OUT_W-1:0] s2_dat_q, s2_dat_d;
    logic             s2_err_q, s2_err_d;

    logic             s1_adv, s2_adv;
    logic [LEN_W-1:0] len_c;
    logic [OUT_W-1:0] keep;
    logic [IN_W-1:0]  data_sh;
    logic             sign;

    assign s2_adv   = !s2_v_q || out_ready;
    assign s1_adv   = !s1_v_q || s2_adv;
    assign in_ready = s1_adv;

    always_comb begin
        len_c    = (in_len > IN_W_L) ? IN_W_L : in_len;
        s1_err_d = (in_len > IN_W_L);
        keep     = ~({OUT_W{1'b1}} << len_c);
        // For len_c == 0 the shift amount wraps, but sign is gated off below.
        data_sh  = in_data >> (len_c - LEN_W'(1));
        sign     = (len_c != '0) && data_sh[0] && !in_mode[0];
        s1_val_d = (OUT_W'(in_data) & keep) | (sign ? ~keep : '0);
        case (in_mode)
            2'b10:   s1_sh_d = 6'd2;
            2'b11:   s1_sh_d = {in_hw, 4'b0000};
            default: s1_sh_d = 6'd0;
        endcase
    end

    always_comb begin
        s2_dat_d = s1_val_q << s1_sh_q;
        // Flag any set bit in the top s1_sh_q positions, which the shift pushes out.
        s2_err_d = s1_err_q || (|(s1_val_q & ~({OUT_W{1'b1}} >> s1_sh_q)));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_v_q   <= 1'b0;
            s1_val_q <= '0;
            s1_sh_q  <= '0;
            s1_err_q <= 1'b0;
            s2_v_q   <= 1'b0;
            s2_dat_q <= '0;
            s2_err_q <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_v_q   <= in_valid;
                s1_val_q <= s1_val_d;
                s1_sh_q  <= s1_sh_d;
                s1_err_q <= s1_err_d;
            end
            if (s2_adv) begin
                s2_v_q   <= s1_v_q;
                s2_dat_q <= s2_dat_d;
                s2_err_q <= s2_err_d;
            end
        end
    end

    assign out_valid = s2_v_q;
    assign out_data  = s2_dat_q;
    assign out_err   = s2_err_q;

`ifdef EXT_STATS_EN
    logic [31:0] xfer_cnt_q, xfer_cnt_d;

    assign xfer_cnt_d = xfer_cnt_q + 32'd1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            xfer_cnt_q <= '0;
        end else if (in_valid && s1_adv) begin
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    assign xfer_cnt = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_ext_unit_pipe.sv
// Directed bench for ext_unit_pipe: hand-computed vectors, backpressure ordering, and reset mid-stall.
module tb_ext_unit_pipe;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [25:0] in_data;
    logic [4:0]  in_len;
    logic [1:0]  in_mode;
    logic [1:0]  in_hw;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_err;
`ifdef EXT_STATS_EN
    logic [31:0] xfer_cnt;
`endif

    int n_tests;
    int n_fail;
    int exp_xfer;

    ext_unit_pipe dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_len    (in_len),
        .in_mode   (in_mode),
        .in_hw     (in_hw),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err)
`ifdef EXT_STATS_EN
        ,
        .xfer_cnt  (xfer_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    task automatic run(input string tag, input logic [4:0] len, input logic [25:0] dat,
                       input logic [1:0] mode, input logic [1:0] hw,
                       input logic [63:0] exp_dat, input logic exp_err);
        in_len    = len;
        in_data   = dat;
        in_mode   = mode;
        in_hw     = hw;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_rdy"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        exp_xfer++;
        @(negedge clk);
        check({tag, "_lat1"}, out_valid, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, "_vld"}, out_valid, 1);
        check({tag, "_dat"}, out_data, exp_dat);
        check({tag, "_err"}, out_err, exp_err);
        @(posedge clk); #1;
    endtask

    initial begin
        int sent;
        int got;
        n_tests   = 0;
        n_fail    = 0;
        exp_xfer  = 0;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_len    = '0;
        in_mode   = '0;
        in_hw     = '0;
        out_ready = 1'b0;

        // Reset for two cycles, then release.
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("rst_vld", out_valid, 0);
        check("rst_dat", out_data, 0);
        check("rst_err", out_err, 0);
        check("rst_rdy", in_ready, 1);
`ifdef EXT_STATS_EN
        check("rst_cnt", xfer_cnt, 0);
`endif
        @(posedge clk); #1;

        run("sext_neg",  5'd9,  26'h00001F8, 2'b00, 2'd0, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0);
        run("sext_pos",  5'd9,  26'h00000F8, 2'b00, 2'd0, 64'h0000_0000_0000_00F8, 1'b0);
        run("zext_hi",   5'd9,  26'h3FFFEF8, 2'b01, 2'd0, 64'h0000_0000_0000_00F8, 1'b0);
        run("branch",    5'd26, 26'h3FFFFFF, 2'b10, 2'd0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
        run("branch_hw", 5'd4,  26'h0000005, 2'b10, 2'd3, 64'h0000_0000_0000_0014, 1'b0);
        run("movz_hw3",  5'd16, 26'h000BEEF, 2'b11, 2'd3, 64'hBEEF_0000_0000_0000, 1'b0);
        run("movz_hw0",  5'd16, 26'h000FFFF, 2'b11, 2'd0, 64'h0000_0000_0000_FFFF, 1'b0);
        run("movz_hw2",  5'd26, 26'h3FFFFFF, 2'b11, 2'd2, 64'h03FF_FFFF_0000_0000, 1'b0);
        run("movz_drop", 5'd26, 26'h3FFFFFF, 2'b11, 2'd3, 64'hFFFF_0000_0000_0000, 1'b1);
        run("len0",      5'd0,  26'h3FFFFFF, 2'b00, 2'd0, 64'h0000_0000_0000_0000, 1'b0);
        run("len31_z",   5'd31, 26'h3FFFFFF, 2'b01, 2'd0, 64'h0000_0000_03FF_FFFF, 1'b1);
        run("len31_s",   5'd31, 26'h2000000, 2'b00, 2'd0, 64'hFFFF_FFFF_FE00_0000, 1'b1);

        // Four back-to-back inputs with the consumer stalled for the first five cycles.
        sent    = 0;
        got     = 0;
        in_len  = 5'd26;
        in_mode = 2'b01;
        in_hw   = 2'd0;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            in_valid  = (sent < 4);
            in_data   = 26'(32'h100 + sent);
            out_ready = (cyc >= 5);
            @(negedge clk);
            if (cyc >= 2 && cyc <= 4) begin
                check("bp_stall_rdy", in_ready, 0);
                check("bp_hold_vld", out_valid, 1);
                check("bp_hold_dat", out_data, 64'h100);
            end
            if (cyc == 5) check("bp_accepted", sent, 2);
            if (out_valid && out_ready) begin
                check("bp_order", out_data, 64'h100 + 64'(got));
                got++;
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        exp_xfer += 4;
        check("bp_count", got, 4);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_nodup", out_valid, 0);
            @(posedge clk); #1;
        end

        // Reset while two items sit stalled in the pipe.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 26'h0000AAA;
        @(posedge clk); #1;
        in_data   = 26'h0000BBB;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        exp_xfer += 2;
        @(posedge clk); #1;
        @(negedge clk);
        check("rs_stalled_vld", out_valid, 1);
        check("rs_stalled_dat", out_data, 64'hAAA);
`ifdef EXT_STATS_EN
        check("rs_cnt", xfer_cnt, 64'(exp_xfer));
`endif
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("rs_vld", out_valid, 0);
        check("rs_dat", out_data, 0);
        check("rs_rdy", in_ready, 1);
`ifdef EXT_STATS_EN
        check("rs_cnt0", xfer_cnt, 0);
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("rs_gone", out_valid, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
